fic0_apb_slot_ctrl: RTL and testbench
=====================================

Name: fic0_apb_slot_ctrl

Overview:
- Fabric-side controller for the MSS FIC_0 APB3 master port.
- Decodes each transfer to one of NUM_SLOTS fabric APB slaves and routes the request to that slave.
- Muxes the selected slave's response back to the MSS.
- Completes unmapped accesses with an error, and aborts any transfer a slave stalls beyond TIMEOUT cycles, so the Cortex-M3 never hangs on FIC_0.
- Keeps a saturating error counter and a capture of the last failing address.

Parameters:
- NUM_SLOTS, 4, number of downstream slaves (1..8).
- SLOT_LSB, 12, slot index = PADDR[SLOT_LSB +: clog2(NUM_SLOTS)]; each slot spans 2^SLOT_LSB bytes.
- BASE_ADDR, 32'h5000_0000, FIC_0 window base.
- BASE_MSB, 31, PADDR[BASE_MSB:SLOT_LSB+clog2(NUM_SLOTS)] must equal the same bits of BASE_ADDR for a hit.
- TIMEOUT, 255, maximum wait cycles in ACCESS before abort (1..1023).

Ports:
- MCCC_CLK_BASE, in, 1, APB clock, same as MSS FIC_0 clock.
- MSS_RESET_N_M2F, in, 1, asynchronous active-low reset.
- FIC_0_APB_M_PADDR, in, 32, from MSS.
- FIC_0_APB_M_PSEL, in, 1, from MSS.
- FIC_0_APB_M_PENABLE, in, 1, from MSS.
- FIC_0_APB_M_PWRITE, in, 1, from MSS.
- FIC_0_APB_M_PWDATA, in, 32, from MSS.
- FIC_0_APB_M_PRDATA, out, 32, to MSS.
- FIC_0_APB_M_PREADY, out, 1, to MSS.
- FIC_0_APB_M_PSLVERR, out, 1, to MSS.
- SLV_PSEL, out, NUM_SLOTS, one-hot slave select.
- SLV_PENABLE, out, 1, shared.
- SLV_PADDR, out, 32, shared, passthrough.
- SLV_PWRITE, out, 1, shared, passthrough.
- SLV_PWDATA, out, 32, shared, passthrough.
- SLV_PRDATA, in, 32*NUM_SLOTS, slot i at [32i+31:32i].
- SLV_PREADY, in, NUM_SLOTS, per-slot ready.
- SLV_PSLVERR, in, NUM_SLOTS, per-slot error.
- ERR_COUNT, out, 16, saturating count of error completions (unmapped + timeout).
- ERR_ADDR, out, 32, PADDR of the most recent error completion.
- TIMEOUT_PULSE, out, 1, one-cycle pulse when a timeout abort is issued.

Behaviour:
- Decode (combinational on PADDR):
  - hit = base bits match AND slot index < NUM_SLOTS.
  - slot = index bits.
- FSM states:
  - IDLE -> SETUP on PSEL & !PENABLE.
  - SETUP -> ACCESS next cycle.
  - ACCESS:
    - Hit: stays in ACCESS until the selected SLV_PREADY=1, then -> IDLE, or -> SETUP if PSEL & !PENABLE in the following cycle (back-to-back per APB3).
    - Miss: completes in its first ACCESS cycle.
  - ABORT: entered from ACCESS when wait_cnt == TIMEOUT and SLV_PREADY still 0; lasts exactly 1 cycle, then -> IDLE.
- SLV_PSEL[i] = PSEL & hit & (slot==i) & state!=ABORT; the slave is dropped in the abort cycle.
- SLV_PENABLE = PENABLE & state!=ABORT. Address, write and write-data buses are pure passthrough.
- Upstream response:
  - Hit, not ABORT: PRDATA/PREADY/PSLVERR = selected slave's signals.
  - Miss in ACCESS: PREADY=1, PSLVERR=1, PRDATA=0.
  - ABORT: PREADY=1, PSLVERR=1, PRDATA=32'hDEAD_0000 | slot.
  - Otherwise PREADY=0, PSLVERR=0, PRDATA=0.
- wait_cnt (10 bit):
  - Cleared in IDLE/SETUP.
  - Increments each ACCESS cycle that SLV_PREADY=0.
  - Timeout fires on the cycle wait_cnt==TIMEOUT, so the abort completion arrives TIMEOUT+1 cycles after first ACCESS cycle.
- Error capture:
  - On each error completion (miss, ABORT, or slave PSLVERR with PREADY), ERR_COUNT += 1, saturating at 16'hFFFF, and ERR_ADDR <= PADDR.
  - A slave-reported error counts once.
- Simultaneous events: if SLV_PREADY rises on the same cycle wait_cnt==TIMEOUT, the slave completion wins; there is no abort.
- PSEL deasserted mid-ACCESS (MSS protocol violation): FSM -> IDLE, no error counted.
- Reset (asynchronous, any time including mid-transfer):
  - FSM IDLE, wait_cnt 0, ERR_COUNT 0, ERR_ADDR 0, TIMEOUT_PULSE 0.
  - All SLV_PSEL 0, SLV_PENABLE 0, upstream PREADY/PSLVERR 0, PRDATA 0.
  - Outputs gated by IDLE while reset is asserted.
- TIMEOUT_PULSE is 1 exactly in the ABORT cycle.

Test Plan:
- Write 0x5000_1004 = 0xA5A5_1234, slot 1 with 2 wait states -> SLV_PSEL=4'b0010 through SETUP+3 ACCESS cycles; upstream PREADY on the 3rd ACCESS cycle; PSLVERR=0; ERR_COUNT stays 0.
- Read 0x5000_3010, slot 3 returns 0x1234_5678 with 0 waits -> PRDATA=0x1234_5678 on the first ACCESS cycle; back-to-back read to slot 0 gets SLV_PSEL=4'b0001 the next cycle.
- Read 0x6000_0000 (unmapped) -> no SLV_PSEL; first ACCESS cycle gives PREADY=1, PSLVERR=1, PRDATA=0; ERR_COUNT=1, ERR_ADDR=0x6000_0000.
- TIMEOUT=8, slot 2 never ready -> ABORT 9 cycles after the first ACCESS cycle; PRDATA=0xDEAD_0002, PSLVERR=1, TIMEOUT_PULSE one cycle, SLV_PSEL drops in ABORT; next transfer proceeds normally.
- Slot 0 asserts PREADY on the same cycle wait_cnt==TIMEOUT -> normal completion, TIMEOUT_PULSE=0, ERR_COUNT unchanged.
- Assert MSS_RESET_N_M2F low mid-ACCESS -> all outputs 0 asynchronously, ERR_COUNT=0; after release, the first transfer completes correctly. Force ERR_COUNT to 0xFFFF and issue one more error -> it stays at 0xFFFF.

Source files
------------

// File: rtl/fic0_apb_slot_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fic0_apb_slot_ctrl
// Brief   : FIC_0 APB3 slot decoder/router with unmapped-error and timeout abort
// Revision: 1.0 - initial release
// ============================================================================
module fic0_apb_slot_ctrl #(
  parameter int          NUM_SLOTS = 4,
  parameter int          SLOT_LSB  = 12,
  parameter logic [31:0] BASE_ADDR = 32'h5000_0000,
  parameter int          BASE_MSB  = 31,
  parameter int          TIMEOUT   = 255
) (
  input  logic                    MCCC_CLK_BASE,
  input  logic                    MSS_RESET_N_M2F,
  input  logic [31:0]             FIC_0_APB_M_PADDR,
  input  logic                    FIC_0_APB_M_PSEL,
  input  logic                    FIC_0_APB_M_PENABLE,
  input  logic                    FIC_0_APB_M_PWRITE,
  input  logic [31:0]             FIC_0_APB_M_PWDATA,
  output logic [31:0]             FIC_0_APB_M_PRDATA,
  output logic                    FIC_0_APB_M_PREADY,
  output logic                    FIC_0_APB_M_PSLVERR,
  output logic [NUM_SLOTS-1:0]    SLV_PSEL,
  output logic                    SLV_PENABLE,
  output logic [31:0]             SLV_PADDR,
  output logic                    SLV_PWRITE,
  output logic [31:0]             SLV_PWDATA,
  input  logic [32*NUM_SLOTS-1:0] SLV_PRDATA,
  input  logic [NUM_SLOTS-1:0]    SLV_PREADY,
  input  logic [NUM_SLOTS-1:0]    SLV_PSLVERR,
  output logic [15:0]             ERR_COUNT,
  output logic [31:0]             ERR_ADDR,
  output logic                    TIMEOUT_PULSE
);

  localparam int          C_SW    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int          C_BLO   = SLOT_LSB + ((NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 0);
  localparam logic [9:0]  C_TO    = 10'(TIMEOUT);
  localparam logic [31:0] C_DEAD  = 32'hDEAD_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ABORT  = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_cur;
  state_t       w_nxt;
  logic [9:0]   r_wait_cnt;
  logic [15:0]  r_err_count;
  logic [31:0]  r_err_addr;
  logic [15:0]  w_err_count_nxt;

  logic [C_SW-1:0] w_slot;
  logic            w_base_hit;
  logic            w_hit;
  logic            w_sel_rdy;
  logic            w_sel_err;
  logic [31:0]     w_sel_data;
  logic            w_err;
  logic [31:0]     w_prdata;
  logic            w_pready;
  logic            w_pslverr;

  generate
    if (NUM_SLOTS > 1) begin : g_multi_slot
      assign w_slot = FIC_0_APB_M_PADDR[SLOT_LSB +: C_SW];
    end else begin : g_single_slot
      assign w_slot = '0;
    end
  endgenerate

  assign w_base_hit = (FIC_0_APB_M_PADDR[BASE_MSB:C_BLO] == BASE_ADDR[BASE_MSB:C_BLO]);
  assign w_hit      = w_base_hit && (int'(w_slot) < NUM_SLOTS);
  assign w_sel_rdy  = SLV_PREADY[w_slot];
  assign w_sel_err  = SLV_PSLVERR[w_slot];
  assign w_sel_data = SLV_PRDATA[w_slot*32 +: 32];

  // The register holds what the previous cycle committed to; the bus phase of
  // the current cycle also depends on the MSS inputs, so SETUP is never stored.
  always_comb begin
    w_cur = ST_IDLE;
    if (MSS_RESET_N_M2F) begin
      case (r_state)
        ST_ABORT: w_cur = ST_ABORT;
        ST_ACCESS: begin
          if (FIC_0_APB_M_PSEL && FIC_0_APB_M_PENABLE) w_cur = ST_ACCESS;
          else if (FIC_0_APB_M_PSEL)                   w_cur = ST_SETUP;
        end
        default: begin
          if (FIC_0_APB_M_PSEL && !FIC_0_APB_M_PENABLE) w_cur = ST_SETUP;
        end
      endcase
    end
  end

  always_comb begin
    w_nxt     = ST_IDLE;
    w_err     = 1'b0;
    w_prdata  = '0;
    w_pready  = 1'b0;
    w_pslverr = 1'b0;
    case (w_cur)
      ST_SETUP: begin
        w_nxt = ST_ACCESS;
        if (w_hit) begin
          w_prdata  = w_sel_data;
          w_pready  = w_sel_rdy;
          w_pslverr = w_sel_err;
        end
      end
      ST_ACCESS: begin
        if (!w_hit) begin
          w_pready  = 1'b1;
          w_pslverr = 1'b1;
          w_err     = 1'b1;
        end else begin
          w_prdata  = w_sel_data;
          w_pready  = w_sel_rdy;
          w_pslverr = w_sel_err;
          // A slave completing on the timeout cycle takes priority over the abort.
          if (w_sel_rdy)                  w_err = w_sel_err;
          else if (r_wait_cnt == C_TO)    w_nxt = ST_ABORT;
          else                            w_nxt = ST_ACCESS;
        end
      end
      ST_ABORT: begin
        w_prdata  = C_DEAD | 32'(w_slot);
        w_pready  = 1'b1;
        w_pslverr = 1'b1;
        w_err     = 1'b1;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge MCCC_CLK_BASE or negedge MSS_RESET_N_M2F) begin
    if (!MSS_RESET_N_M2F) r_state <= ST_IDLE;
    else                  r_state <= w_nxt;
  end

  always_ff @(posedge MCCC_CLK_BASE or negedge MSS_RESET_N_M2F) begin
    if (!MSS_RESET_N_M2F)                             r_wait_cnt <= '0;
    else if (w_cur == ST_ACCESS && w_hit && !w_sel_rdy) r_wait_cnt <= r_wait_cnt + 10'd1;
    else                                              r_wait_cnt <= '0;
  end

  assign w_err_count_nxt = (w_err && (r_err_count != 16'hFFFF)) ? r_err_count + 16'd1
                                                                : r_err_count;

  always_ff @(posedge MCCC_CLK_BASE or negedge MSS_RESET_N_M2F) begin
    if (!MSS_RESET_N_M2F) begin
      r_err_count <= '0;
      r_err_addr  <= '0;
    end else begin
      r_err_count <= w_err_count_nxt;
      if (w_err) r_err_addr <= FIC_0_APB_M_PADDR;
    end
  end

  generate
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_psel
      assign SLV_PSEL[i] = MSS_RESET_N_M2F && FIC_0_APB_M_PSEL && w_hit &&
                           (int'(w_slot) == i) && (w_cur != ST_ABORT);
    end
  endgenerate

  assign SLV_PENABLE         = MSS_RESET_N_M2F && FIC_0_APB_M_PENABLE && (w_cur != ST_ABORT);
  assign SLV_PADDR           = FIC_0_APB_M_PADDR;
  assign SLV_PWRITE          = FIC_0_APB_M_PWRITE;
  assign SLV_PWDATA          = FIC_0_APB_M_PWDATA;
  assign FIC_0_APB_M_PRDATA  = w_prdata;
  assign FIC_0_APB_M_PREADY  = w_pready;
  assign FIC_0_APB_M_PSLVERR = w_pslverr;
  assign ERR_COUNT           = r_err_count;
  assign ERR_ADDR            = r_err_addr;
  assign TIMEOUT_PULSE       = (w_cur == ST_ABORT);

endmodule
`default_nettype wire

// File: tb/tb_fic0_apb_slot_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fic0_apb_slot_ctrl
// Brief   : Directed + randomized bench for fic0_apb_slot_ctrl (TIMEOUT = 8)
// Revision: 1.0 - initial release
// ============================================================================
module tb_fic0_apb_slot_ctrl;

  localparam int          TO   = 8;
  localparam logic [31:0] BASE = 32'h5000_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  paddr, pwdata, prdata;
  logic         psel, penable, pwrite, pready, pslverr;
  logic [3:0]   slv_psel, slv_pready, slv_pslverr;
  logic         slv_penable, slv_pwrite;
  logic [31:0]  slv_paddr, slv_pwdata;
  logic [127:0] slv_prdata;
  logic [15:0]  err_count;
  logic [31:0]  err_addr;
  logic         to_pulse;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [15:0]  m_cnt   = '0;
  logic [31:0]  m_addr  = '0;

  // Behavioural slaves: slot i becomes ready after s_wait[i] ACCESS cycles.
  logic [31:0]  s_data [4];
  int           s_wait [4];
  logic         s_err  [4];
  int           s_cnt  [4];

  always #5 clk = ~clk;

  fic0_apb_slot_ctrl #(.NUM_SLOTS(4), .SLOT_LSB(12), .BASE_ADDR(BASE),
                       .BASE_MSB(31), .TIMEOUT(TO)) dut (
    .MCCC_CLK_BASE      (clk),
    .MSS_RESET_N_M2F    (rst_n),
    .FIC_0_APB_M_PADDR  (paddr),
    .FIC_0_APB_M_PSEL   (psel),
    .FIC_0_APB_M_PENABLE(penable),
    .FIC_0_APB_M_PWRITE (pwrite),
    .FIC_0_APB_M_PWDATA (pwdata),
    .FIC_0_APB_M_PRDATA (prdata),
    .FIC_0_APB_M_PREADY (pready),
    .FIC_0_APB_M_PSLVERR(pslverr),
    .SLV_PSEL           (slv_psel),
    .SLV_PENABLE        (slv_penable),
    .SLV_PADDR          (slv_paddr),
    .SLV_PWRITE         (slv_pwrite),
    .SLV_PWDATA         (slv_pwdata),
    .SLV_PRDATA         (slv_prdata),
    .SLV_PREADY         (slv_pready),
    .SLV_PSLVERR        (slv_pslverr),
    .ERR_COUNT          (err_count),
    .ERR_ADDR           (err_addr),
    .TIMEOUT_PULSE      (to_pulse)
  );

  always_comb begin
    slv_pready  = '0;
    slv_pslverr = '0;
    slv_prdata  = '0;
    for (int i = 0; i < 4; i++) begin
      slv_pready[i]         = slv_psel[i] && slv_penable && (s_cnt[i] >= s_wait[i]);
      slv_pslverr[i]        = slv_pready[i] && s_err[i];
      slv_prdata[32*i +: 32] = s_data[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      s_cnt[i] <= (slv_psel[i] && slv_penable && !slv_pready[i]) ? s_cnt[i] + 1 : 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int slot, input int w, input logic e, input logic [31:0] d);
    s_wait[slot] = w;
    s_err[slot]  = e;
    s_data[slot] = d;
  endtask

  task automatic idle(input int n);
    psel    = 1'b0;
    penable = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // One APB transfer, starting at a falling edge; returns at the falling edge
  // after completion so the caller may issue a back-to-back SETUP immediately.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd);
    logic        hit, eerr, eabort, done;
    int          slot, ecyc, k;
    logic [31:0] edata;
    logic [3:0]  esel;
    hit  = (addr[31:14] == BASE[31:14]);
    slot = int'(addr[13:12]);
    esel = hit ? (4'b0001 << slot) : 4'b0000;
    if (!hit) begin
      ecyc = 0; edata = '0; eerr = 1'b1; eabort = 1'b0;
    end else if (s_wait[slot] <= TO) begin
      ecyc = s_wait[slot]; edata = s_data[slot]; eerr = s_err[slot]; eabort = 1'b0;
    end else begin
      ecyc = TO + 1; edata = 32'hDEAD_0000 + slot; eerr = 1'b1; eabort = 1'b1;
    end

    paddr = addr; pwrite = wr; pwdata = wd; psel = 1'b1; penable = 1'b0;
    #1 chk("setup_psel", {28'd0, slv_psel}, {28'd0, esel});
    @(negedge clk);
    penable = 1'b1;
    k = 0;
    done = 1'b0;
    while (!done && k < 1100) begin
      #1;
      if (pready === 1'b1) done = 1'b1;
      else begin
        chk("wait_pulse", {31'd0, to_pulse}, 32'd0);
        @(negedge clk);
        k++;
      end
    end
    chk("completed", {31'd0, done}, 32'd1);
    if (done) begin
      chk("latency", k, ecyc);
      chk("prdata", prdata, edata);
      chk("pslverr", {31'd0, pslverr}, {31'd0, eerr});
      chk("tmo_pulse", {31'd0, to_pulse}, {31'd0, eabort});
      chk("done_psel", {28'd0, slv_psel}, eabort ? 32'd0 : {28'd0, esel});
      chk("pass_addr", slv_paddr, addr);
      chk("pass_wdata", slv_pwdata, wd);
      chk("pass_write", {31'd0, slv_pwrite}, {31'd0, wr});
    end
    if (eerr) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_addr = addr;
    end
    @(negedge clk);
    chk("err_count", {16'd0, err_count}, {16'd0, m_cnt});
    chk("err_addr", err_addr, m_addr);
  endtask

  initial begin
    logic [31:0] a;
    int          sl, r;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    for (int i = 0; i < 4; i++) cfg(i, 0, 1'b0, 32'h0);

    @(negedge clk);
    #1;
    chk("rst_psel", {28'd0, slv_psel}, 32'd0);
    chk("rst_pready", {31'd0, pready}, 32'd0);
    chk("rst_errcnt", {16'd0, err_count}, 32'd0);
    chk("rst_erraddr", err_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Write with two wait states on slot 1.
    cfg(1, 2, 1'b0, 32'h1111_0001);
    xfer(32'h5000_1004, 1'b1, 32'hA5A5_1234);
    idle(1);

    // Zero-wait read of slot 3, then back-to-back read of slot 0.
    cfg(3, 0, 1'b0, 32'h1234_5678);
    cfg(0, 0, 1'b0, 32'h0BAD_CAFE);
    xfer(32'h5000_3010, 1'b0, 32'h0);
    xfer(32'h5000_0008, 1'b0, 32'h0);
    idle(1);

    // Unmapped address.
    xfer(32'h6000_0000, 1'b0, 32'h0);
    idle(1);

    // Slot 2 never ready: abort, then a normal back-to-back transfer.
    cfg(2, 1000, 1'b0, 32'h2222_2222);
    cfg(1, 1, 1'b0, 32'h3333_3333);
    xfer(32'h5000_2000, 1'b0, 32'h0);
    xfer(32'h5000_1000, 1'b0, 32'h0);
    idle(1);

    // Slave ready on the exact timeout cycle wins over abort.
    cfg(0, TO, 1'b0, 32'h4444_4444);
    xfer(32'h5000_0100, 1'b0, 32'h0);
    idle(1);

    // Slave-reported error counts once.
    cfg(3, 3, 1'b1, 32'h5555_5555);
    xfer(32'h5000_3FFC, 1'b1, 32'h1);
    idle(1);

    // PSEL dropped mid-ACCESS: no error, next transfer normal.
    cfg(1, 1000, 1'b0, 32'h0);
    paddr = 32'h5000_1008; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge clk); penable = 1'b1;
    repeat (3) @(negedge clk);
    idle(1);
    #1;
    chk("drop_psel", {28'd0, slv_psel}, 32'd0);
    chk("drop_errcnt", {16'd0, err_count}, {16'd0, m_cnt});
    @(negedge clk);
    cfg(1, 0, 1'b0, 32'h6666_6666);
    xfer(32'h5000_1008, 1'b0, 32'h0);
    idle(1);

    // Randomized traffic, mixed hits/misses/aborts/back-to-back.
    for (int n = 0; n < 40; n++) begin
      sl = $urandom_range(0, 3);
      r  = $urandom_range(0, 5);
      if (r == 0)      begin a = $urandom; a[31] = 1'b1; end
      else if (r == 1) a = BASE | (32'(sl) << 12) | 32'h4000;
      else             a = BASE | (32'(sl) << 12) | ($urandom & 32'hFFF);
      cfg(sl, $urandom_range(0, 10), ($urandom_range(0, 3) == 0), $urandom);
      xfer(a, 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
    end
    idle(1);

    // Asynchronous reset in the middle of an ACCESS phase.
    cfg(2, 1000, 1'b0, 32'h7777_7777);
    paddr = 32'h5000_2040; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge clk); penable = 1'b1;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_psel", {28'd0, slv_psel}, 32'd0);
    chk("arst_penable", {31'd0, slv_penable}, 32'd0);
    chk("arst_pready", {31'd0, pready}, 32'd0);
    chk("arst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("arst_prdata", prdata, 32'd0);
    chk("arst_pulse", {31'd0, to_pulse}, 32'd0);
    chk("arst_errcnt", {16'd0, err_count}, 32'd0);
    chk("arst_erraddr", err_addr, 32'd0);
    m_cnt = '0; m_addr = '0;
    @(negedge clk);
    idle(1);
    rst_n = 1'b1;
    @(negedge clk);
    cfg(2, 1, 1'b0, 32'h8888_8888);
    xfer(32'h5000_2044, 1'b0, 32'h0);
    idle(1);

    // Error counter saturation.
    force dut.r_err_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_err_count;
    m_cnt = 16'hFFFF;
    xfer(32'h7000_0010, 1'b0, 32'h0);
    idle(2);
    chk("sat_hold", {16'd0, err_count}, 32'h0000_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
